window_3x3_gen: RTL
===================

Name: window_3x3_gen

Overview:
Producer side of the 3x3 neighbourhood interface used by the blur/edge filters. It takes a raster-ordered RGB332 pixel stream and presents a registered 3x3 window per interior pixel, with neighbours named a0..a7 around the centre pix. It sits between the frame-buffer read path and the filter stage; the consumer slices each byte into r[7:5], g[4:2], b[1:0].

Parameters:
IMG_WIDTH, 320, pixels per line (>= 3)
IMG_HEIGHT, 240, lines per frame (>= 3)
PIX_W, 8, bits per pixel (RGB332)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
in_pix  in  PIX_W  input pixel, raster order
in_valid  in  1  qualifies in_pix; one pixel per cycle when high
in_sof  in  1  start of frame; meaningful only with in_valid
a0, a1, a2  out  PIX_W each  row cy-1: columns cx-1, cx, cx+1
a7, pix, a3  out  PIX_W each  row cy: columns cx-1, cx, cx+1
a6, a5, a4  out  PIX_W each  row cy+1: columns cx-1, cx, cx+1
out_valid  out  1  window registers hold a valid window (one-cycle pulse per window)

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high.
- Counters x (0..IMG_WIDTH-1) and y (0..IMG_HEIGHT-1) advance only on in_valid beats. x wraps to 0 and increments y. After (IMG_WIDTH-1, IMG_HEIGHT-1), both wrap to 0 without needing in_sof.
- in_sof with in_valid forces that beat to coordinate (0,0), aborting any partial frame. in_sof without in_valid is ignored.
- Line store: one read-first RAM, depth IMG_WIDTH, word {row y-2, row y-1}. On each beat at column x:
  - read word[x];
  - write word[x] <= {old row y-1 byte, in_pix}.
- Stage 1 (edge of the beat) registers the column {row y-2, row y-1, in_pix}.
- Stage 2 shifts that column into the 3x3 register array: left column becomes a0/a7/a6, then middle, then the newest as a2/a3/a4.
- A window is emitted for the beat at (x,y) only when x >= 2 and y >= 2; its centre is (cx, cy) = (x-1, y-1). Only interior centres are produced: (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame.
- Latency: out_valid rises exactly 2 cycles after the qualifying in_valid beat.
- in_valid gaps: gaps stall counters and the shift array. Windows are unaffected by gap length, and out_valid stays low during gaps.
- Window registers hold their last value while out_valid is low.
- The line RAM is not reset; its stale contents never reach a window because windows require y >= 2.
- Reset values: out_valid=0, all window outputs=0, x=y=0, pipeline valid bits=0.
- Reset mid-frame: in-flight windows are dropped, out_valid=0 from the next cycle, and the next in_valid beat is (0,0).
- in_sof mid-frame: windows already in stage 1/2 still emit. The new frame emits nothing until its (2,2) beat.

Optional Feature:
- Macro WINDOW_COORD_EN.
- When defined: adds outputs out_cx [$clog2(IMG_WIDTH)-1:0] and out_cy [$clog2(IMG_HEIGHT)-1:0], giving the centre coordinate. Both are registered alongside the window, are valid with out_valid, and reset to 0.
- When undefined: these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package: default IMG_WIDTH/IMG_HEIGHT, PIX_W, RGB332 field slice constants (R_HI=7, R_LO=5, G_HI=4, G_LO=2, B_HI=1, B_LO=0), coordinate widths.
- One sub-module, window_line_ram: single-port read-first RAM, depth IMG_WIDTH, width 2*PIX_W, 1-cycle read latency.

Test Plan:
- IMG_WIDTH=IMG_HEIGHT=4, pixel value = y*4+x, continuous in_valid with in_sof on the first pixel:
  - first window is a0=0 a1=1 a2=2 a7=4 pix=5 a3=6 a6=8 a5=9 a4=10, with out_valid 2 cycles after the beat of pixel 10;
  - exactly 4 windows per frame (centres 5, 6, 9, 10).
- Same image with random 0-3 cycle in_valid gaps: identical window sequence, each out_valid exactly 2 cycles after its triggering beat.
- Two back-to-back frames, the second without in_sof and with values +16: the first window of frame 2 has pix=21 and contains no frame-1 values.
- in_sof asserted at pixel (1,2) of frame 1: at most the already-triggered windows emit, then no out_valid until the new frame's (2,2) beat.
- rst held 1 cycle at pixel (3,2): out_valid=0 and all outputs=0 next cycle; the following frame's first window is correct.
- With WINDOW_COORD_EN defined, 4x4 image: out_cx/out_cy sequence is (1,1), (2,1), (1,2), (2,2).

Source files
------------

// File: rtl/window_3x3_gen_pkg.sv
// Shared constants for the 3x3 window generator: default image geometry,
// RGB332 field positions and the coordinate-width helper.
package window_3x3_gen_pkg;

  localparam int DEF_IMG_WIDTH  = 320;
  localparam int DEF_IMG_HEIGHT = 240;
  localparam int DEF_PIX_W      = 8;

  // RGB332 byte layout as sliced by the filter stage
  localparam int R_HI = 7;
  localparam int R_LO = 5;
  localparam int G_HI = 4;
  localparam int G_LO = 2;
  localparam int B_HI = 1;
  localparam int B_LO = 0;

  function automatic int coord_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_CX_W = coord_w(DEF_IMG_WIDTH);
  localparam int DEF_CY_W = coord_w(DEF_IMG_HEIGHT);

endpackage

// File: rtl/window_line_ram.sv
// Single-port read-first line store. Each enabled access returns the old word
// one cycle later and writes back {old low byte, new pixel}, ageing rows y-1 -> y-2.
module window_line_ram
  import window_3x3_gen_pkg::*;
#(
  parameter int DEPTH = DEF_IMG_WIDTH,
  parameter int PIX_W = DEF_PIX_W
) (
  input  logic                       clk,
  input  logic                       i_en,
  input  logic [coord_w(DEPTH)-1:0]  i_addr,
  input  logic [PIX_W-1:0]           i_wpix,
  output logic [2*PIX_W-1:0]         o_rdata
);

  logic [2*PIX_W-1:0] r_mem [DEPTH];
  logic [2*PIX_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      r_rdata       <= r_mem[i_addr];
      r_mem[i_addr] <= {r_mem[i_addr][PIX_W-1:0], i_wpix};
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/window_3x3_gen.sv
// Raster RGB332 stream to registered 3x3 neighbourhood, one window per interior
// pixel, 2 cycles after the beat. Define WINDOW_COORD_EN to add out_cx/out_cy.
module window_3x3_gen
  import window_3x3_gen_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int PIX_W      = DEF_PIX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] in_pix,
  input  logic             in_valid,
  input  logic             in_sof,
  output logic [PIX_W-1:0] a0,
  output logic [PIX_W-1:0] a1,
  output logic [PIX_W-1:0] a2,
  output logic [PIX_W-1:0] a7,
  output logic [PIX_W-1:0] pix,
  output logic [PIX_W-1:0] a3,
  output logic [PIX_W-1:0] a6,
  output logic [PIX_W-1:0] a5,
  output logic [PIX_W-1:0] a4,
  output logic             out_valid
`ifdef WINDOW_COORD_EN
  ,
  output logic [coord_w(IMG_WIDTH)-1:0]  out_cx,
  output logic [coord_w(IMG_HEIGHT)-1:0] out_cy
`endif
);

  localparam int XW = coord_w(IMG_WIDTH);
  localparam int YW = coord_w(IMG_HEIGHT);
  localparam int CW = 3 * PIX_W;

  // Handshake: in_valid qualifies one pixel per cycle and is never back-pressured;
  // out_valid is a one-cycle strobe marking a fresh window, with no ready input.

  logic [XW-1:0]      r_x;
  logic [YW-1:0]      r_y;
  logic [XW-1:0]      w_x;
  logic [YW-1:0]      w_y;
  logic               w_last_x;
  logic               w_last_y;
  logic               w_win;

  logic               r_s1_valid;
  logic               r_s1_win;
  logic [PIX_W-1:0]   r_s1_pix;
  logic [2*PIX_W-1:0] w_rd;
  logic [CW-1:0]      w_col;

  logic [CW-1:0]      r_col_l;
  logic [CW-1:0]      r_col_m;
  logic [CW-1:0]      r_left;
  logic [CW-1:0]      r_mid;
  logic [CW-1:0]      r_right;
  logic               r_out_valid;

  // A start-of-frame beat is treated as coordinate (0,0) regardless of counters
  assign w_x      = in_sof ? '0 : r_x;
  assign w_y      = in_sof ? '0 : r_y;
  assign w_last_x = (w_x == XW'(IMG_WIDTH - 1));
  assign w_last_y = (w_y == YW'(IMG_HEIGHT - 1));
  assign w_win    = in_valid && (w_x >= XW'(2)) && (w_y >= YW'(2));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (in_valid) begin
      if (w_last_x) begin
        r_x <= '0;
        r_y <= w_last_y ? '0 : w_y + YW'(1);
      end else begin
        r_x <= w_x + XW'(1);
        r_y <= w_y;
      end
    end
  end

  window_line_ram #(
    .DEPTH (IMG_WIDTH),
    .PIX_W (PIX_W)
  ) u_line_ram (
    .clk     (clk),
    .i_en    (in_valid && !rst),
    .i_addr  (w_x),
    .i_wpix  (in_pix),
    .o_rdata (w_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_win   <= 1'b0;
      r_s1_pix   <= '0;
    end else begin
      r_s1_valid <= in_valid;
      r_s1_win   <= w_win;
      if (in_valid) begin
        r_s1_pix <= in_pix;
      end
    end
  end

  // Column for the stage-1 beat, top to bottom: rows y-2, y-1, y
  assign w_col = {w_rd[2*PIX_W-1:PIX_W], w_rd[PIX_W-1:0], r_s1_pix};

  // History columns advance on every beat; window outputs load only on windows
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col_l     <= '0;
      r_col_m     <= '0;
      r_left      <= '0;
      r_mid       <= '0;
      r_right     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_s1_win;
      if (r_s1_valid) begin
        r_col_l <= r_col_m;
        r_col_m <= w_col;
      end
      if (r_s1_win) begin
        r_left  <= r_col_l;
        r_mid   <= r_col_m;
        r_right <= w_col;
      end
    end
  end

  assign a0        = r_left[CW-1:2*PIX_W];
  assign a7        = r_left[2*PIX_W-1:PIX_W];
  assign a6        = r_left[PIX_W-1:0];
  assign a1        = r_mid[CW-1:2*PIX_W];
  assign pix       = r_mid[2*PIX_W-1:PIX_W];
  assign a5        = r_mid[PIX_W-1:0];
  assign a2        = r_right[CW-1:2*PIX_W];
  assign a3        = r_right[2*PIX_W-1:PIX_W];
  assign a4        = r_right[PIX_W-1:0];
  assign out_valid = r_out_valid;

`ifdef WINDOW_COORD_EN
  logic [XW-1:0] r_s1_cx;
  logic [YW-1:0] r_s1_cy;
  logic [XW-1:0] r_out_cx;
  logic [YW-1:0] r_out_cy;

  // Centre is one column left and one row up from the triggering beat
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_cx  <= '0;
      r_s1_cy  <= '0;
      r_out_cx <= '0;
      r_out_cy <= '0;
    end else begin
      if (in_valid) begin
        r_s1_cx <= w_x - XW'(1);
        r_s1_cy <= w_y - YW'(1);
      end
      if (r_s1_win) begin
        r_out_cx <= r_s1_cx;
        r_out_cy <= r_s1_cy;
      end
    end
  end

  assign out_cx = r_out_cx;
  assign out_cy = r_out_cy;
`endif

endmodule
